div_iter: RTL and testbench

- Iterative radix-2 restoring divider, one quotient bit per cycle, with signed/unsigned and 32/64-bit support.
- Acts as the responder on the MDU divide handshake: in_valid, out_ready, out_valid, quotient and remainder.
- Sits under the MDU in the execute stage and returns quotient and remainder together.
- Results follow RISC-V M-extension semantics, including divide-by-zero and overflow.

---
 rtl/mdu_pkg.sv | 17 +
 rtl/div_step.sv | 25 ++
 rtl/div_iter.sv | 162 ++++++++++++++++
 tb/tb_div_iter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: datapath width, the
// divider state encoding and the RISC-V special-case result constants.
package mdu_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [XLEN-1:0] MOST_NEG      = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor magnitude when it fits.
module div_step
    import mdu_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] rem,
    input  logic         dvd_bit,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    // The partial remainder can reach 2*|divisor|-1, so it needs one extra bit.
    logic [W:0] partial;

    // Compare-and-restore on the widened partial remainder.
    always_comb begin
        partial  = {rem, dvd_bit};
        q_bit    = (partial >= {1'b0, dvs});
        rem_next = q_bit ? W'(partial - {1'b0, dvs}) : partial[W-1:0];
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with RISC-V M-extension semantics.
// Operands are reduced to magnitudes at accept, one quotient bit is produced
// per CALC cycle, and signs plus DIVW sign-extension are applied at DONE.
module div_iter
    import mdu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            divw,
    input  logic            div_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int HALF = XLEN / 2;

    div_state_e              state, state_next;
    logic [CNT_W-1:0]        cnt;
    logic                    accept, step_en, publish;

    logic signed [XLEN-1:0]  op_a, op_b;
    logic                    a_neg, b_neg, b_zero, ovf, special;
    logic [XLEN-1:0]         a_abs, b_abs;

    logic                    divw_q, skip_q, q_neg, r_neg;
    logic [XLEN-1:0]         dvd_sh, dvs_abs, rem_acc;
    logic [XLEN-1:0]         step_rem;
    logic                    step_qbit;

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag,
                                                   input logic neg);
        return neg ? -mag : mag;
    endfunction

    function automatic logic [XLEN-1:0] fit_width(input logic [XLEN-1:0] v,
                                                  input logic w);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    // Operand conditioning: extend 32-bit operands, take magnitudes, and
    // detect the two cases whose result is fixed by the ISA.
    always_comb begin
        if (divw) begin
            op_a = div_signed ? {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]}
                              : {{HALF{1'b0}}, dividend[HALF-1:0]};
            op_b = div_signed ? {{HALF{divisor[HALF-1]}}, divisor[HALF-1:0]}
                              : {{HALF{1'b0}}, divisor[HALF-1:0]};
            b_zero = (divisor[HALF-1:0] == '0);
            ovf    = div_signed && (dividend[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}})
                                && (divisor[HALF-1:0] == '1);
        end else begin
            op_a   = dividend;
            op_b   = divisor;
            b_zero = (divisor == '0);
            ovf    = div_signed && (dividend == MOST_NEG) && (divisor == '1);
        end
        a_neg   = div_signed & op_a[XLEN-1];
        b_neg   = div_signed & op_b[XLEN-1];
        a_abs   = a_neg ? -op_a : op_a;
        b_abs   = b_neg ? -op_b : op_b;
        special = b_zero | ovf;
    end

    div_step #(.W(XLEN)) u_step (
        .rem      (rem_acc),
        .dvd_bit  (dvd_sh[XLEN-1]),
        .dvs      (dvs_abs),
        .rem_next (step_rem),
        .q_bit    (step_qbit)
    );

    // State register; flush returns to IDLE like reset but keeps results.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= DIV_IDLE;
        end else if (flush) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: every request passes through CALC so special cases share
    // the same publish path (they spend a single, non-iterating cycle there).
    always_comb begin
        state_next = state;
        unique case (state)
            DIV_IDLE: if (in_valid) state_next = DIV_CALC;
            DIV_CALC: if (cnt == CNT_W'(1)) state_next = DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // FSM outputs and datapath enables; flush blocks both accept and publish.
    always_comb begin
        out_ready = (state == DIV_IDLE);
        accept    = in_valid & out_ready & ~flush;
        step_en   = (state == DIV_CALC) & ~skip_q;
        publish   = (state == DIV_DONE) & ~flush;
    end

    // Iteration counter: loaded with the bit count at accept, counts down in CALC.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= special ? CNT_W'(1) : (divw ? CNT_W'(HALF) : CNT_W'(XLEN));
        end else if (state == DIV_CALC) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Working registers: special results are preloaded unsigned so DONE only
    // has to apply the DIVW extension; normal operands are left-aligned so
    // the MSB of dvd_sh is always the next dividend bit.
    always_ff @(posedge clock) begin
        if (accept) begin
            divw_q  <= divw;
            dvs_abs <= b_abs;
            skip_q  <= special;
            if (special) begin
                dvd_sh  <= b_zero ? DIV_BY_ZERO_Q : op_a;
                rem_acc <= b_zero ? op_a : '0;
                q_neg   <= 1'b0;
                r_neg   <= 1'b0;
            end else begin
                dvd_sh  <= divw ? {a_abs[HALF-1:0], {HALF{1'b0}}} : a_abs;
                rem_acc <= '0;
                q_neg   <= a_neg ^ b_neg;
                r_neg   <= a_neg;
            end
        end else if (step_en) begin
            dvd_sh  <= {dvd_sh[XLEN-2:0], step_qbit};
            rem_acc <= step_rem;
        end
    end

    // Result registers: updated only on an unflushed DONE, pulse out_valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            out_valid <= publish;
            if (publish) begin
                quotient  <= fit_width(apply_sign(dvd_sh, q_neg), divw_q);
                remainder <= fit_width(apply_sign(rem_acc, r_neg), divw_q);
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed table, random operands against
// an arithmetic reference, and flush/reset corner sequences.
module tb_div_iter;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        divw;
    logic        div_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] last_q = '0;
    logic [63:0] last_r = '0;

    div_iter dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .divw       (divw),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        w;
        logic        s;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: RISC-V M semantics written directly with native division.
    task automatic ref_div(input logic w, input logic s, input logic [63:0] a,
                           input logic [63:0] b, output logic [63:0] q,
                           output logic [63:0] r, output int lat);
        logic [31:0] a32, b32, q32, r32;
        int          sa32, sb32;
        longint      sa, sb;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            lat = 33;
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32; lat = 2;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0; lat = 2;
            end else if (s) begin
                sa32 = a32; sb32 = b32;
                q32 = 32'(sa32 / sb32);
                r32 = 32'(sa32 % sb32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            lat = 65;
            if (b == 64'd0) begin
                q = '1; r = a; lat = 2;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = '0; lat = 2;
            end else if (s) begin
                sa = a; sb = b;
                q = 64'(sa / sb);
                r = 64'(sa % sb);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endtask

    // Issue one request, follow it to out_valid and check everything about it.
    task automatic do_op(input string nm, input logic w, input logic s,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er, input int elat);
        int   lat;
        logic busy_bad;
        @(negedge clock);
        check({nm, " ready"}, 64'(out_ready), 64'd1);
        in_valid = 1'b1; divw = w; div_signed = s; dividend = a; divisor = b;
        @(posedge clock); #1;
        in_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        busy_bad = out_ready;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clock); lat++; #1;
            if (!out_valid && out_ready) busy_bad = 1'b1;
        end
        check({nm, " latency"}, 64'(lat), 64'(elat));
        check({nm, " quotient"}, quotient, eq);
        check({nm, " remainder"}, remainder, er);
        check({nm, " busy"}, 64'(busy_bad), 64'd0);
        check({nm, " ready_at_valid"}, 64'(out_ready), 64'd1);
        @(posedge clock); #1;
        check({nm, " pulse"}, 64'(out_valid), 64'd0);
        check({nm, " held_q"}, quotient, eq);
        last_q = eq;
        last_r = er;
    endtask

    // Watch a window of cycles and report whether out_valid ever rose.
    task automatic watch_no_valid(input string nm, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        check({nm, " no_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic        rw, rs;
        logic [63:0] ra, rb, rq, rr;
        int          rl;
        logic        rdy_bad;

        tbl[0]  = '{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65};
        tbl[1]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                    64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        tbl[2]  = '{1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 2};
        tbl[3]  = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, 64'd0, 2};
        tbl[4]  = '{1'b1, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2,
                    64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        tbl[5]  = '{1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd1,
                    64'hFFFF_FFFF_8000_0000, 64'd0, 33};
        tbl[6]  = '{1'b1, 1'b0, 64'd7, 64'hABCD_0000_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 2};
        tbl[7]  = '{1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                    64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65};
        tbl[8]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
        tbl[9]  = '{1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                    64'hFFFF_FFFF_8000_0000, 64'd0, 2};
        tbl[10] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2};
        tbl[11] = '{1'b1, 1'b0, 64'h1234_5678_FFFF_FFFF, 64'd16,
                    64'h0000_0000_0FFF_FFFF, 64'd15, 33};

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        divw = 1'b0; div_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset quotient", quotient, 64'd0);
        check("reset remainder", remainder, 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_ready", 64'(out_ready), 64'd1);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].b,
                  tbl[i].q, tbl[i].r, tbl[i].lat);
        end

        // Flush on the 10th CALC cycle of a 64-bit divide.
        @(negedge clock);
        in_valid = 1'b1; divw = 1'b0; div_signed = 1'b0; dividend = 64'd100; divisor = 64'd7;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush out_ready", 64'(out_ready), 64'd1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush held_q", quotient, last_q);
        check("flush held_r", remainder, last_r);
        watch_no_valid("flush", 70);
        do_op("after_flush", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);

        // Flush coinciding with an accept: the request must not be taken.
        @(negedge clock);
        in_valid = 1'b1; flush = 1'b1; divw = 1'b0; div_signed = 1'b0;
        dividend = 64'd5; divisor = 64'd0;
        @(posedge clock); #1;
        in_valid = 1'b0; flush = 1'b0;
        rdy_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (!out_ready) rdy_bad = 1'b1;
        end
        check("flush_accept ready", 64'(rdy_bad), 64'd0);
        check("flush_accept held_q", quotient, last_q);

        // Flush coinciding with DONE: no pulse, results untouched.
        @(negedge clock);
        in_valid = 1'b1; dividend = 64'd5; divisor = 64'd0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_done out_valid", 64'(out_valid), 64'd0);
        check("flush_done held_q", quotient, last_q);
        check("flush_done held_r", remainder, last_r);
        check("flush_done out_ready", 64'(out_ready), 64'd1);
        watch_no_valid("flush_done", 4);

        // Reset in the middle of CALC.
        @(negedge clock);
        in_valid = 1'b1; divw = 1'b0; div_signed = 1'b1;
        dividend = 64'hFFFF_FFFF_FFFF_FFF9; divisor = 64'd2;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        check("midreset quotient", quotient, 64'd0);
        check("midreset remainder", remainder, 64'd0);
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset out_ready", 64'(out_ready), 64'd1);
        last_q = '0;
        last_r = '0;
        watch_no_valid("midreset", 70);

        // Random operands with a bias toward the interesting divisors.
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: rb = 64'($urandom_range(1, 20));
                3: begin ra = 64'h8000_0000_0000_0000; rb = '1; end
                4: begin ra = 64'hFFFF_FFFF_8000_0000; rb = 64'h0000_0000_FFFF_FFFF; end
                5: rb = rb >> $urandom_range(0, 63);
                default: ;
            endcase
            ref_div(rw, rs, ra, rb, rq, rr, rl);
            do_op($sformatf("rnd%0d", i), rw, rs, ra, rb, rq, rr, rl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
